// File: rtl/sigma_delta_adc_sequencer.sv
// sigma_delta_adc_sequencer
// Time-multiplexes one sigma-delta ADC across NCH analog inputs through an
// external analog mux. After every channel switch it drops the settling
// samples. It then averages 2^AVG_LOG2 decimated samples and presents one
// channel-tagged result on a valid/ready port.
module sigma_delta_adc_sequencer #(
  parameter int NCH      = 4,
  parameter int WDTH     = 16,
  parameter int SETTLE   = 2,
  parameter int AVG_LOG2 = 2,
  parameter int CH_W     = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [WDTH-1:0]  adc_output,
  input  logic             adc_valid,
  output logic [CH_W-1:0]  mux_sel,
  output logic [WDTH-1:0]  res_data,
  output logic [CH_W-1:0]  res_ch,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int NAVG  = 1 << AVG_LOG2;
  localparam int ACC_W = WDTH + AVG_LOG2;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  // Terminal counts. When SETTLE is 0 the settle state cannot be reached, so
  // the wrapped value of SETTLE_LAST is never used.
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [AVG_W-1:0] AVG_LAST    = AVG_W'(NAVG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t             state;
  logic               first_conv;   // next conversion must settle even on the same channel
  logic               start_zero;   // first search after reset includes channel 0
  logic [SET_W-1:0]   settle_cnt;
  logic [AVG_W-1:0]   avg_cnt;
  logic [ACC_W-1:0]   acc;
  logic [CH_W-1:0]    next_ch;
  logic [CH_W-1:0]    cand;
  logic               found;

  // Returns the i-th candidate channel in search order. The normal search
  // starts at mux_sel+1 and wraps. The first search after reset starts at 0.
  function automatic int cand_idx(input int i, input logic [CH_W-1:0] base,
                                  input logic zero);
    if (zero) return i;
    return (int'(base) + 1 + i) % NCH;
  endfunction

  // Find the next enabled channel, searching upward and wrapping.
  // NOTE: every variable gets a default before the loop, so no path through
  // this block can leave a value undriven and infer a latch.
  always_comb begin
    next_ch = mux_sel;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = CH_W'(cand_idx(i, mux_sel, start_zero));
      if (!found && ch_mask[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  // Sequencer FSM: selects the channel, settles, accumulates and holds the result.
  // NOTE: all state here uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      mux_sel    <= '0;
      res_data   <= '0;
      res_ch     <= '0;
      res_valid  <= 1'b0;
      first_conv <= 1'b1;
      start_zero <= 1'b1;
      settle_cnt <= '0;
      avg_cnt    <= '0;
      acc        <= '0;
    end else begin
      // An accepted result drops valid. A reload in OUTPUT below overrides
      // this, so the port can take results back-to-back.
      if (res_valid && res_ready) res_valid <= 1'b0;

      if (!enable && (state == S_SELECT || state == S_SETTLE || state == S_ACCUM)) begin
        // Abort: throw away the partial conversion. Any pending result stays.
        state      <= S_IDLE;
        first_conv <= 1'b1;
        settle_cnt <= '0;
        avg_cnt    <= '0;
        acc        <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (enable && (ch_mask != '0)) state <= S_SELECT;
          end

          S_SELECT: begin
            if (ch_mask == '0) begin
              state <= S_IDLE;
            end else begin
              mux_sel    <= next_ch;
              start_zero <= 1'b0;
              // Repeating the same channel needs no settling. The first
              // conversion after reset or abort always settles.
              if ((SETTLE != 0) && ((next_ch != mux_sel) || first_conv))
                state <= S_SETTLE;
              else
                state <= S_ACCUM;
            end
          end

          S_SETTLE: begin
            if (adc_valid) begin
              if (settle_cnt == SETTLE_LAST) begin
                settle_cnt <= '0;
                state      <= S_ACCUM;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end

          S_ACCUM: begin
            if (adc_valid) begin
              // The accumulator is AVG_LOG2 bits wider than a sample, so a
              // full block of samples cannot overflow it.
              acc <= acc + ACC_W'(adc_output);
              if (avg_cnt == AVG_LAST) begin
                avg_cnt <= '0;
                state   <= S_OUTPUT;
              end else begin
                avg_cnt <= avg_cnt + 1'b1;
              end
            end
          end

          S_OUTPUT: begin
            // Load only when the output register is free or is being
            // accepted this cycle. Otherwise stall and ignore samples.
            if (!res_valid || res_ready) begin
              res_data   <= acc[ACC_W-1:AVG_LOG2];
              res_ch     <= mux_sel;
              res_valid  <= 1'b1;
              acc        <= '0;
              first_conv <= 1'b0;
              state      <= enable ? S_SELECT : S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // busy is decoded directly from the state register.
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sigma_delta_adc_sequencer.sv
// Testbench for sigma_delta_adc_sequencer. A transaction-level predictor
// pushes expected {channel, mean} pairs as ADC samples are driven. A monitor
// pops them on every accepted result.
module tb_sigma_delta_adc_sequencer;

  localparam int NCH      = 4;
  localparam int WDTH     = 16;
  localparam int SETTLE   = 2;
  localparam int AVG_LOG2 = 2;
  localparam int CH_W     = 2;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [NCH-1:0]   ch_mask;
  logic [WDTH-1:0]  adc_output;
  logic             adc_valid;
  logic [CH_W-1:0]  mux_sel;
  logic [WDTH-1:0]  res_data;
  logic [CH_W-1:0]  res_ch;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  always #5 clk = ~clk;

  sigma_delta_adc_sequencer #(
    .NCH(NCH), .WDTH(WDTH), .SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .adc_output(adc_output), .adc_valid(adc_valid), .mux_sel(mux_sel),
    .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Predictor state: current channel, settling left, partial sum.
  int   m_cur;
  bit   m_first;
  bit   m_zero;
  int   m_settle;
  int   m_cnt;
  int   m_sum;
  int   k_seq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int model_search();
    if (m_zero) begin
      for (int i = 0; i < NCH; i++) if (ch_mask[i]) return i;
    end else begin
      for (int i = 1; i <= NCH; i++) begin
        int idx;
        idx = (m_cur + i) % NCH;
        if (ch_mask[idx]) return idx;
      end
    end
    return m_cur;
  endfunction

  task automatic model_start();
    int nxt;
    nxt      = model_search();
    m_settle = ((nxt != m_cur) || m_first) ? SETTLE : 0;
    m_cur    = nxt;
    m_zero   = 1'b0;
    m_cnt    = 0;
    m_sum    = 0;
  endtask

  task automatic model_abort();
    m_first  = 1'b1;
    m_settle = 0;
    m_cnt    = 0;
    m_sum    = 0;
  endtask

  task automatic model_pulse(input int v);
    exp_t e;
    if (m_settle > 0) begin
      m_settle--;
    end else begin
      check("mux_sel", 32'(mux_sel), 32'(m_cur));
      m_sum += v;
      m_cnt++;
      if (m_cnt == NAVG) begin
        e.ch   = m_cur;
        e.data = m_sum >> AVG_LOG2;
        exp_q.push_back(e);
        m_first = 1'b0;
        model_start();
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle adc_valid strobe followed by a 5-cycle gap.
  task automatic pulse(input int v, input bit use_model);
    adc_output = WDTH'(v);
    adc_valid  = 1'b1;
    if (use_model) model_pulse(v);
    @(posedge clk);
    #1;
    adc_valid  = 1'b0;
    adc_output = WDTH'($urandom);
    cycles(5);
  endtask

  // The analog mux model: the sample value depends on the selected input.
  task automatic pulse_ch();
    pulse(int'(mux_sel) * 100 + k_seq, 1'b1);
    k_seq++;
  endtask

  // Scoreboard monitor: every accepted result must match the next expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_ch", 32'(res_ch), 32'(e.ch));
      end
    end
  end

  initial begin
    m_cur = 0; m_first = 1'b1; m_zero = 1'b1;
    m_settle = 0; m_cnt = 0; m_sum = 0; k_seq = 0;

    // Test 1: reset with random inputs, then idle with enable low.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enable     = 1'($urandom);
      ch_mask    = NCH'($urandom);
      adc_output = WDTH'($urandom);
      adc_valid  = 1'($urandom);
      res_ready  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_ch", 32'(res_ch), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1; enable = 1'b0; ch_mask = 4'b1111; adc_valid = 1'b0; res_ready = 1'b1;
    cycles(4);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_res_valid", 32'(res_valid), 32'd0);

    // Test 2: alternate channels 0 and 2, four conversions.
    ch_mask = 4'b0101; enable = 1'b1;
    model_start();
    cycles(3);
    for (int i = 0; i < 4 * (SETTLE + NAVG); i++) pulse_ch();
    enable = 1'b0; model_abort();
    cycles(3);
    check("t2_drain", 32'(exp_q.size()), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // Test 3: single channel 3. Only the first conversion settles.
    ch_mask = 4'b1000; enable = 1'b1;
    model_start();
    cycles(3);
    pulse(500, 1'b1); pulse(500, 1'b1);
    pulse(7, 1'b1); pulse(8, 1'b1); pulse(8, 1'b1); pulse(8, 1'b1);
    pulse(20, 1'b1); pulse(21, 1'b1); pulse(22, 1'b1); pulse(23, 1'b1);
    enable = 1'b0; model_abort();
    cycles(3);
    check("t3_drain", 32'(exp_q.size()), 32'd0);

    // Test 4: back-pressure. One result is held while a second stalls in OUTPUT.
    ch_mask = 4'b0010; res_ready = 1'b0; enable = 1'b1;
    model_start();
    cycles(3);
    for (int i = 0; i < SETTLE + 2 * NAVG; i++) pulse_ch();
    for (int i = 0; i < 3 * NAVG; i++) begin
      pulse(1234, 1'b0);
      if ((i % NAVG) == NAVG - 1) begin
        check("stall_valid", 32'(res_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        if (exp_q.size() > 0) check("stall_data", 32'(res_data), 32'(exp_q[0].data));
        else check("stall_expect", 32'd0, 32'd1);
      end
    end
    res_ready = 1'b1;
    cycles(3);
    check("t4_accept", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < NAVG; i++) pulse_ch();
    check("t4_drain", 32'(exp_q.size()), 32'd0);

    // Test 5: abort mid-accumulation. The partial sum must be discarded.
    pulse(1000, 1'b1); pulse(1000, 1'b1);
    enable = 1'b0;
    cycles(1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    model_abort();
    cycles(3);
    enable = 1'b1;
    model_start();
    cycles(3);
    pulse(999, 1'b1); pulse(999, 1'b1);
    pulse(40, 1'b1); pulse(41, 1'b1); pulse(42, 1'b1); pulse(43, 1'b1);
    enable = 1'b0; model_abort();
    cycles(3);
    check("t5_drain", 32'(exp_q.size()), 32'd0);

    // Test 6: an empty mask keeps the FSM idle. A mask change mid-ACCUM
    // applies from the next SELECT.
    ch_mask = 4'b0000; enable = 1'b1;
    cycles(5);
    check("t6_idle_busy", 32'(busy), 32'd0);
    ch_mask = 4'b0001;
    model_start();
    cycles(3);
    for (int i = 0; i < SETTLE + 2; i++) pulse_ch();
    ch_mask = 4'b0100;
    for (int i = 0; i < 2; i++) pulse_ch();
    for (int i = 0; i < SETTLE + NAVG; i++) pulse_ch();
    enable = 1'b0; model_abort();
    cycles(3);
    check("t6_drain", 32'(exp_q.size()), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
